tree_search_ctrl: RTL
=====================

// Module: tree_search_ctrl
// PURPOSE
//  Sequential binary-search engine over a heap-ordered (Eytzinger) key memory: root at addr 1, children of n at 2n / 2n+1.
//  Walks the tree one level per two cycles, comparing a latched search key against memory data.
//  Reports hit/miss, hit address and levels visited.
//  Sits between the search requester and a single-port sync-read key RAM.
//  Successor to the fixed 8-bit, match-only combinational next-address ROM.
// PARAMETERS
//  D      8      key/data width
//  A      8      memory address width; valid nodes 1 .. 2^A-1, addr 0 unused
//  EMPTY  {D{1'b1}}  sentinel marking an unoccupied node
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          async active-low reset
//  start       in   1          search request; sampled only when busy=0
//  key         in   D          search key; sampled with start
//  busy        out  1          high from first cycle after accepted start through DONE
//  done        out  1          one-cycle pulse: result valid
//  found       out  1          hit flag; valid while done=1, held until next accepted start
//  found_addr  out  A          hit address; 0 on miss; held like found
//  levels      out  $clog2(A+1)  number of nodes compared; held like found
//  mem_rd_en   out  1          read strobe to key RAM
//  mem_addr    out  A          read address
//  mem_rdata   in   D          read data, valid one cycle after mem_rd_en
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy, done, found, mem_rd_en = 0; found_addr, levels, mem_addr = 0; key register 0.
//  FSM: IDLE -> FETCH -> COMPARE -> (FETCH | DONE) -> IDLE.
//  IDLE: start=1 -> latch key, addr<=1, levels<=0, found<=0, found_addr<=0; -> FETCH.
//  FETCH: mem_rd_en=1, mem_addr=addr; -> COMPARE. mem_rd_en=0 in all other states.
//  COMPARE (mem_rdata valid), levels<=levels+1, first matching rule wins:
//   1) mem_rdata==EMPTY -> miss; -> DONE.
//   2) mem_rdata==key -> found<=1, found_addr<=addr; -> DONE.
//   3) addr[A-1]==1 (child would overflow A bits) -> miss; -> DONE.
//   4) key<mem_rdata (unsigned) -> addr<={addr[A-2:0],1'b0}; key>mem_rdata -> addr<={addr[A-2:0],1'b1}; -> FETCH.
//  DONE: done=1 for exactly one cycle; -> IDLE.
//  Latency: hit/miss decided at depth k (root k=0) -> done high 2k+3 cycles after start sampled; max 2A+1.
//  start while busy=1 or in DONE: ignored, no queuing; key not re-latched.
//  start on cycle after done: accepted normally (back-to-back searches allowed).
//  key==EMPTY: search runs; terminates as miss at first occupied-or-empty rule per above.
//  Reset mid-search: immediate abort to reset values; no done pulse.
//  levels never exceeds A; width $clog2(A+1) holds value A.
// STRUCTURE
//  Shared package tree_search_pkg: state enum (IDLE, FETCH, COMPARE, DONE); child-address function next_addr(addr, go_right).
//  One sub-module natural: tree_next_addr -- combinational A-bit child generator with overflow flag (parametrised replacement for the old next-address ROM).
//  Remainder: FSM, key/addr/levels registers, result registers in one always_ff block plus next-state logic.
// TESTING  (D=8, A=3, EMPTY=8'hFF; RAM model 1-cycle read; mem[1..7]=40,20,60,10,30,50,70)
//  start,key=40 -> mem_addr=1 once; done at cycle 3, found=1, found_addr=1, levels=1.
//  start,key=70 -> addr path 1,3,7; done at cycle 7, found=1, found_addr=7, levels=3.
//  start,key=35 -> path 1,2,5 then overflow; done at cycle 7, found=0, found_addr=0, levels=3.
//  mem[3]=8'hFF, start,key=60 -> path 1,3; EMPTY hit; done at cycle 5, found=0, levels=2.
//  start,key=70 then start,key=10 at cycle 2 -> second start ignored, result for 70; start,key=10 on cycle after done -> found_addr=4.
//  rst_n low at cycle 4 of key=70 search -> all outputs 0 same cycle, no done; release, start,key=20 -> found_addr=2, levels=2.

Source files
------------

// File: rtl/tree_search_pkg.sv
// Shared types and helpers for the heap-ordered key-memory search engine.
package tree_search_pkg;

  // Search controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Widest address the child helper supports; callers truncate to their own width.
  localparam int ADDR_MAX_W = 32;

  // Eytzinger child of node addr: left = 2n, right = 2n+1.
  function automatic logic [ADDR_MAX_W-1:0] next_addr(input logic [ADDR_MAX_W-1:0] addr,
                                                      input logic                  go_right);
    return {addr[ADDR_MAX_W-2:0], go_right};
  endfunction

endpackage

// File: rtl/tree_search_ctrl_next_addr.sv
// Combinational child-address generator with overflow flag.
module tree_next_addr
  import tree_search_pkg::*;
#(
  parameter int A = 8
) (
  input  logic [A-1:0] addr_i,
  input  logic         go_right_i,
  output logic [A-1:0] child_o,
  output logic         ovf_o
);

  // Child of the current node; the MSB shifted out means the child does not fit in A bits.
  assign child_o = A'(next_addr(ADDR_MAX_W'(addr_i), go_right_i));
  assign ovf_o   = addr_i[A-1];

endmodule

// File: rtl/tree_search_ctrl.sv
// Sequential binary search over a heap-ordered key RAM, one tree level per two cycles.
module tree_search_ctrl
  import tree_search_pkg::*;
#(
  parameter int           D     = 8,
  parameter int           A     = 8,
  parameter logic [D-1:0] EMPTY = {D{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [D-1:0]             key,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [A-1:0]             found_addr,
  output logic [$clog2(A+1)-1:0]   levels,
  output logic                     mem_rd_en,
  output logic [A-1:0]             mem_addr,
  input  logic [D-1:0]             mem_rdata
);

  localparam int LW = $clog2(A+1);

  state_e          state_q, state_d;
  logic [D-1:0]    key_q, key_d;
  logic [A-1:0]    addr_q, addr_d;
  logic [LW-1:0]   levels_q, levels_d;
  logic            found_q, found_d;
  logic [A-1:0]    found_addr_q, found_addr_d;

  logic [A-1:0]    child;
  logic            child_ovf;
  logic            is_empty;
  logic            is_match;
  logic            go_right;

  assign is_empty = (mem_rdata == EMPTY);
  assign is_match = (mem_rdata == key_q);
  assign go_right = (key_q > mem_rdata);

  tree_next_addr #(.A(A)) u_next_addr (
    .addr_i     (addr_q),
    .go_right_i (go_right),
    .child_o    (child),
    .ovf_o      (child_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a compare ends the walk on empty node, match, or a child that would overflow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = COMPARE;
      COMPARE: state_d = (is_empty || is_match || child_ovf) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    mem_rd_en = (state_q == FETCH);
    mem_addr  = (state_q == FETCH) ? addr_q : '0;
  end

  // Datapath next values: latch request on accept, step down the tree on each compare.
  always_comb begin
    key_d        = key_q;
    addr_d       = addr_q;
    levels_d     = levels_q;
    found_d      = found_q;
    found_addr_d = found_addr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d        = key;
          addr_d       = A'(1);
          levels_d     = '0;
          found_d      = 1'b0;
          found_addr_d = '0;
        end
      end
      COMPARE: begin
        levels_d = levels_q + LW'(1);
        if (!is_empty) begin
          if (is_match) begin
            found_d      = 1'b1;
            found_addr_d = addr_q;
          end else if (!child_ovf) begin
            addr_d = child;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Key, walk address and result registers; results hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      addr_q       <= '0;
      levels_q     <= '0;
      found_q      <= 1'b0;
      found_addr_q <= '0;
    end else begin
      key_q        <= key_d;
      addr_q       <= addr_d;
      levels_q     <= levels_d;
      found_q      <= found_d;
      found_addr_q <= found_addr_d;
    end
  end

  assign found      = found_q;
  assign found_addr = found_addr_q;
  assign levels     = levels_q;

endmodule
